// File: rtl/data_ram_wr_arbiter.sv
// data_ram_wr_arbiter: round-robin owner of the data-table RAM write port with a clear-RAM sweep
// Ports: req_*_i / req_ready_o  per-requester write request and one-hot grant
//        ram_wr_*_o             registered RAM port B write (addr, data, enable)
//        clear_ram_run_i        pulse that starts or restarts a zeroing sweep
//        clear_ram_done_o       pulse aligned with the final sweep write
//        busy_o                 high while sweeping
module data_ram_wr_arbiter #(
  parameter int REQ_CNT = 3,
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [REQ_CNT*A_WIDTH-1:0] req_addr_i,
  input  logic [REQ_CNT*D_WIDTH-1:0] req_data_i,
  input  logic [REQ_CNT-1:0]         req_valid_i,
  output logic [REQ_CNT-1:0]         req_ready_o,
  output logic [A_WIDTH-1:0]         ram_wr_addr_o,
  output logic [D_WIDTH-1:0]         ram_wr_data_o,
  output logic                       ram_wr_en_o,
  input  logic                       clear_ram_run_i,
  output logic                       clear_ram_done_o,
  output logic                       busy_o
);
  localparam int P_W = $clog2(REQ_CNT);
  typedef enum logic {ARB, CLEAR} state_t;
  state_t state_q, state_d;
  logic [A_WIDTH-1:0] clear_addr_q, clear_addr_d, addr_q, addr_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic en_q, en_d, done_q, done_d, found;
  logic [P_W-1:0] rr_q, rr_d, gidx, idx;
  // first valid requester strictly after the last grantee wins
  always_comb begin
    found = 1'b0;
    gidx = rr_q;
    idx = rr_q;
    for (int k = 1; k <= REQ_CNT; k++) begin
      idx = P_W'((int'(rr_q) + k) % REQ_CNT);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gidx = idx;
      end
    end
  end
  assign req_ready_o = (found && !clear_ram_run_i && state_q == ARB) ? REQ_CNT'(1) << gidx : '0;
  always_comb begin
    state_d = state_q;
    clear_addr_d = clear_addr_q;
    addr_d = addr_q;
    data_d = data_q;
    en_d = 1'b0;
    done_d = 1'b0;
    rr_d = rr_q;
    if (state_q == CLEAR) begin
      en_d = 1'b1;
      addr_d = clear_addr_q;
      data_d = '0;
      clear_addr_d = clear_addr_q + 1'b1;
      if (&clear_addr_q) begin
        state_d = ARB;
        done_d = 1'b1;
      end
    end else if (|req_ready_o) begin
      en_d = 1'b1;
      addr_d = A_WIDTH'(req_addr_i >> (int'(gidx) * A_WIDTH));
      data_d = D_WIDTH'(req_data_i >> (int'(gidx) * D_WIDTH));
      rr_d = gidx;
    end
    // a new run always wins: restarts the sweep and cancels any pending done
    if (clear_ram_run_i) begin
      state_d = CLEAR;
      clear_addr_d = '0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      clear_addr_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      rr_q <= P_W'(REQ_CNT - 1);
    end else begin
      state_q <= state_d;
      clear_addr_q <= clear_addr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      en_q <= en_d;
      done_q <= done_d;
      rr_q <= rr_d;
    end
  end
  assign ram_wr_addr_o = addr_q;
  assign ram_wr_data_o = data_q;
  assign ram_wr_en_o = en_q;
  assign clear_ram_done_o = done_q;
  assign busy_o = (state_q == CLEAR);
endmodule

// File: tb/tb_data_ram_wr_arbiter.sv
// tb_data_ram_wr_arbiter: scoreboard bench for the RAM write arbiter and clear sweep
module tb_data_ram_wr_arbiter;
  logic clk = 1'b0, rst = 1'b1, clr_run = 1'b0;
  logic [2:0] valid = '0, ready;
  logic [11:0] req_addr = {4'd9, 4'd5, 4'd1};
  logic [47:0] req_data = {16'h2222, 16'h00AB, 16'h1111};
  logic [3:0] wr_addr;
  logic [15:0] wr_data;
  logic wr_en, done, busy;
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0, d0;
  typedef struct packed {logic [3:0] a; logic [15:0] d; logic dn;} wr_t;
  wr_t q[$];
  data_ram_wr_arbiter #(.REQ_CNT(3), .A_WIDTH(4), .D_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_valid_i(valid), .req_ready_o(ready), .ram_wr_addr_o(wr_addr),
    .ram_wr_data_o(wr_data), .ram_wr_en_o(wr_en), .clear_ram_run_i(clr_run),
    .clear_ram_done_o(done), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic push(input logic [3:0] a, input logic [15:0] d, input logic dn);
    wr_t e;
    e.a = a;
    e.d = d;
    e.dn = dn;
    q.push_back(e);
  endtask
  task automatic step(input logic [2:0] v, input logic clr, input logic [2:0] er,
                      input logic [3:0] ea, input logic [15:0] ed, input logic eb);
    valid = v;
    clr_run = clr;
    @(negedge clk);
    chk("ready", 32'(ready), 32'(er));
    chk("busy", 32'(busy), 32'(eb));
    if (er != 3'b000) push(ea, ed, 1'b0);
    @(posedge clk);
    #1;
    clr_run = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (wr_en) begin
        if (q.size() == 0) begin
          total_cnt++;
          $display("FAIL spurious_write: got addr %0h data %0h, no write expected", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
          chk("wr_done", 32'(done), 32'(e.dn));
        end
      end else if (done) begin
        total_cnt++;
        $display("FAIL done_without_write: got done=1 with wr_en=0, required done=0");
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // full contention from reset: 0,1,2,0,1,2
    repeat (2) begin
      step(3'b111, 1'b0, 3'b001, 4'd1, 16'h1111, 1'b0);
      step(3'b111, 1'b0, 3'b010, 4'd5, 16'h00AB, 1'b0);
      step(3'b111, 1'b0, 3'b100, 4'd9, 16'h2222, 1'b0);
    end
    // single requester
    step(3'b010, 1'b0, 3'b010, 4'd5, 16'h00AB, 1'b0);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    // round-robin skip over an idle requester
    step(3'b001, 1'b0, 3'b001, 4'd1, 16'h1111, 1'b0);
    step(3'b101, 1'b0, 3'b100, 4'd9, 16'h2222, 1'b0);
    step(3'b101, 1'b0, 3'b001, 4'd1, 16'h1111, 1'b0);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    // clear sweep with req0 waiting
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) push(4'(k), 16'h0, k == 15);
    step(3'b001, 1'b1, 3'b000, 4'd0, 16'h0, 1'b0);
    repeat (16) step(3'b001, 1'b0, 3'b000, 4'd0, 16'h0, 1'b1);
    step(3'b001, 1'b0, 3'b001, 4'd1, 16'h1111, 1'b0);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    chk("clear_done_cnt", 32'(done_cnt - d0), 1);
    // restart while clear_addr=7
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) push(4'(k), 16'h0, 1'b0);
    for (int k = 0; k < 16; k++) push(4'(k), 16'h0, k == 15);
    step(3'b000, 1'b1, 3'b000, 4'd0, 16'h0, 1'b0);
    repeat (7) step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b1);
    step(3'b000, 1'b1, 3'b000, 4'd0, 16'h0, 1'b1);
    repeat (16) step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b1);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    chk("restart_done_cnt", 32'(done_cnt - d0), 1);
    // reset while clear_addr=9
    d0 = done_cnt;
    for (int k = 0; k < 9; k++) push(4'(k), 16'h0, 1'b0);
    step(3'b000, 1'b1, 3'b000, 4'd0, 16'h0, 1'b0);
    repeat (9) step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(wr_en), 0);
    chk("midrst_addr", 32'(wr_addr), 0);
    chk("midrst_data", 32'(wr_data), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(3'b011, 1'b0, 3'b001, 4'd1, 16'h1111, 1'b0);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    step(3'b000, 1'b0, 3'b000, 4'd0, 16'h0, 1'b0);
    chk("midrst_done_cnt", 32'(done_cnt - d0), 0);
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/data_ram_wr_arbiter.md
Name: data_ram_wr_arbiter

Overview:
- Owns the single write port of the data-table RAM and shares it between REQ_CNT write requesters (insert engine, delete engine, spare) with round-robin arbitration.
- Contains the clear-RAM sequencer: on request it sweeps every RAM address writing zero, with absolute priority over all requesters.
- Replaces the fixed-priority write mux and the disabled clear logic in data_table; its outputs drive RAM port B directly.

Parameters:
- REQ_CNT, 3, number of write requesters (>=2).
- A_WIDTH, 10, RAM address width (HEAD_PTR_WIDTH in the design).
- D_WIDTH, 64, RAM word width ($bits(ram_data_t) in the design).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_addr_i  in  REQ_CNT*A_WIDTH  write address per requester; slice i belongs to requester i.
- req_data_i  in  REQ_CNT*D_WIDTH  write data per requester; slice i belongs to requester i.
- req_valid_i  in  REQ_CNT  write request per requester.
- req_ready_o  out  REQ_CNT  grant, one-hot or zero.
- ram_wr_addr_o  out  A_WIDTH  RAM write address (registered).
- ram_wr_data_o  out  D_WIDTH  RAM write data (registered).
- ram_wr_en_o  out  1  RAM write enable (registered).
- clear_ram_run_i  in  1  single-cycle pulse that starts a clear sweep.
- clear_ram_done_o  out  1  single-cycle pulse when the sweep completes.
- busy_o  out  1  high while in the CLEAR state.

Behaviour:
- States:
  - ARB: normal arbitration.
  - CLEAR: sweep in progress.
- Reset values: state=ARB, all outputs 0, clear_addr=0, rr_ptr=REQ_CNT-1, so requester 0 wins first.
- ARB grant:
  - req_ready_o is combinational.
  - Search indices rr_ptr+1 .. rr_ptr+REQ_CNT modulo REQ_CNT; the first index with req_valid_i set gets req_ready_o[i]=1. All other bits are 0.
  - No valid requests means req_ready_o=0.
  - req_ready_o is forced to 0 when clear_ram_run_i=1 or state=CLEAR.
- Transfer: happens on req_valid_i[i] && req_ready_o[i].
  - Next cycle: ram_wr_en_o=1 and ram_wr_addr_o/ram_wr_data_o carry slice i. Latency is exactly 1 cycle.
  - rr_ptr <= i.
  - One write per cycle, full throughput. A requester holding valid gets every REQ_CNT-th slot under full contention, and every cycle when it is the only requester.
- Idle cycle: ram_wr_en_o=0. Address and data hold their last values.
- A requester must hold addr/data stable while valid is high and ready is low. Valid may be dropped without a grant.
- Clear start: clear_ram_run_i=1 in any state sets state<=CLEAR and clear_addr<=0.
- CLEAR, each cycle:
  - Register ram_wr_en_o=1, ram_wr_addr_o=clear_addr, ram_wr_data_o=0.
  - clear_addr increments.
  - When clear_addr=={A_WIDTH{1'b1}}: state<=ARB and clear_ram_done_o is registered high. The done pulse coincides with the final write on the outputs.
- The sweep is exactly 2^A_WIDTH consecutive writes. clear_addr wraps to 0 after the last address.
- clear_ram_run_i during CLEAR restarts the sweep: clear_addr<=0, no done pulse for the aborted sweep.
- clear_ram_run_i in the same cycle as a pending valid: no transfer occurs and the requester keeps waiting. rr_ptr is unchanged across the clear.
- busy_o equals (state==CLEAR).
- First cycle back in ARB after a clear: arbitration resumes normally, so a grant is possible in that cycle.
- Reset asserted mid-sweep or mid-write: everything returns to reset values immediately. No done pulse, ram_wr_en_o=0.
- Invariant: ram_wr_en_o is never driven by more than one source per cycle.

Test Plan:
- Single requester: REQ_CNT=3, A_WIDTH=4. Req1 valid, addr=5, data=0xAB for 1 cycle -> ready[1]=1 that cycle; next cycle wr_en=1, addr=5, data=0xAB; then wr_en=0.
- Full contention: req0/1/2 valid continuously -> grant order 0,1,2,0,1,2; 6 writes in 6 cycles; each address/data matches its grantee.
- Round-robin skip: rr_ptr=0 after granting req0, only req0 and req2 valid -> req2 granted next, then req0.
- Clear sweep: A_WIDTH=4, pulse clear_ram_run_i with req0 valid -> ready=0 for 16 cycles; addresses 0..15 written with data 0; done pulse aligned with addr=15; busy_o high for 16 cycles; req0 granted in the first ARB cycle.
- Restart: second clear_ram_run_i while clear_addr=7 -> sweep restarts at 0; exactly one done pulse, after 16 further writes.
- Reset mid-sweep at clear_addr=9 -> outputs 0 and busy_o=0 immediately; no done pulse; req0 wins the first grant after reset.
